// File: rtl/sc_statemachine_window.sv
// sc_statemachine_window: opens one of NUM_WINDOWS programmable {start,end} position windows.
// Define SC_STATEMACHINEWINDOW_COUNT_EN to add the saturating completed-window counter output.
module sc_statemachine_window #(
    parameter int  POS_WIDTH   = 8,
    parameter int  NUM_WINDOWS = 4,
    localparam int IDX_WIDTH   = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1
) (
    input  logic                 SC_STATEMACHINEWINDOW_CLOCK_50,
    input  logic                 SC_STATEMACHINEWINDOW_RESET_InHigh,
    input  logic                 SC_STATEMACHINEWINDOW_startButton_InLow,
    input  logic [POS_WIDTH-1:0] SC_STATEMACHINEWINDOW_FLAG_InLow,
    input  logic                 SC_STATEMACHINEWINDOW_LOAD_InHigh,
    input  logic [IDX_WIDTH-1:0] SC_STATEMACHINEWINDOW_LOADIDX,
    input  logic [POS_WIDTH-1:0] SC_STATEMACHINEWINDOW_LOADSTART,
    input  logic [POS_WIDTH-1:0] SC_STATEMACHINEWINDOW_LOADEND,
    output logic                 SC_STATEMACHINEWINDOW_SENAL,
    output logic [IDX_WIDTH-1:0] SC_STATEMACHINEWINDOW_WINIDX,
    output logic                 SC_STATEMACHINEWINDOW_DONE,
    output logic                 SC_STATEMACHINEWINDOW_LOADERR
`ifdef SC_STATEMACHINEWINDOW_COUNT_EN
    ,
    output logic [7:0]           SC_STATEMACHINEWINDOW_COUNT
`endif
);

    typedef enum logic [2:0] {
        ST_RESET,
        ST_ARMED,
        ST_HOLD,
        ST_ACTIVE,
        ST_CLOSE
    } state_t;

    logic                 clk;
    logic                 rst;
    logic                 hold_req;
    logic [POS_WIDTH-1:0] flag;

    assign clk      = SC_STATEMACHINEWINDOW_CLOCK_50;
    assign rst      = SC_STATEMACHINEWINDOW_RESET_InHigh;
    assign hold_req = !SC_STATEMACHINEWINDOW_startButton_InLow;
    assign flag     = SC_STATEMACHINEWINDOW_FLAG_InLow;

    logic [POS_WIDTH-1:0]   tbl_start [NUM_WINDOWS];
    logic [POS_WIDTH-1:0]   tbl_end   [NUM_WINDOWS];
    logic [NUM_WINDOWS-1:0] tbl_valid;
    logic                   load_err_q;
    logic                   load_idx_ok;
    logic                   load_ordered;

    assign load_idx_ok  = 32'(SC_STATEMACHINEWINDOW_LOADIDX) < NUM_WINDOWS;
    assign load_ordered = SC_STATEMACHINEWINDOW_LOADSTART < SC_STATEMACHINEWINDOW_LOADEND;

    // NOTE: the table is cleared field by field on reset rather than left as uninitialised
    // storage, so no stale valid bit can open a window after reset; it therefore maps to flops.
    // NOTE: all sequential state uses <= so every flop samples pre-edge values; that is also
    // what makes a write on the same edge as an ARMED match invisible to that match.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_WINDOWS; i++) begin
                tbl_start[i] <= '0;
                tbl_end[i]   <= '0;
            end
            tbl_valid  <= '0;
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= SC_STATEMACHINEWINDOW_LOAD_InHigh && !(load_idx_ok && load_ordered);
            if (SC_STATEMACHINEWINDOW_LOAD_InHigh && load_idx_ok) begin
                tbl_start[SC_STATEMACHINEWINDOW_LOADIDX] <= SC_STATEMACHINEWINDOW_LOADSTART;
                tbl_end[SC_STATEMACHINEWINDOW_LOADIDX]   <= SC_STATEMACHINEWINDOW_LOADEND;
                tbl_valid[SC_STATEMACHINEWINDOW_LOADIDX] <= load_ordered;
            end
        end
    end

    logic                 hit;
    logic [IDX_WIDTH-1:0] hit_idx;
    logic [POS_WIDTH-1:0] hit_end;

    // Scanning downwards lets the lowest matching index be the last one written.
    // NOTE: every variable assigned here gets a default first, so no latch is inferred.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_end = '0;
        for (int i = NUM_WINDOWS - 1; i >= 0; i--) begin
            if (tbl_valid[i] && (tbl_start[i] == flag)) begin
                hit     = 1'b1;
                hit_idx = IDX_WIDTH'(i);
                hit_end = tbl_end[i];
            end
        end
    end

    state_t               state_q, state_d;
    logic [IDX_WIDTH-1:0] win_idx_q, win_idx_d;
    logic [POS_WIDTH-1:0] win_end_q, win_end_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RESET;
            win_idx_q <= '0;
            win_end_q <= '0;
        end else begin
            state_q   <= state_d;
            win_idx_q <= win_idx_d;
            win_end_q <= win_end_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        win_idx_d = win_idx_q;
        win_end_d = win_end_q;
        case (state_q)
            ST_RESET: state_d = ST_ARMED;
            ST_ARMED: begin
                if (hold_req) begin
                    state_d = ST_HOLD;
                end else if (hit) begin
                    state_d   = ST_ACTIVE;
                    win_idx_d = hit_idx;
                    win_end_d = hit_end;
                end
            end
            ST_HOLD: begin
                if (!hold_req) state_d = ST_ARMED;
            end
            // The hold request aborts an open window even on its end position.
            ST_ACTIVE: begin
                if (hold_req) begin
                    state_d = ST_HOLD;
                end else if (flag == win_end_q) begin
                    state_d = ST_CLOSE;
                end
            end
            ST_CLOSE: state_d = ST_ARMED;
            default:  state_d = ST_RESET;
        endcase
    end

    assign SC_STATEMACHINEWINDOW_SENAL   = (state_q == ST_ACTIVE);
    assign SC_STATEMACHINEWINDOW_DONE    = (state_q == ST_CLOSE);
    assign SC_STATEMACHINEWINDOW_WINIDX  = win_idx_q;
    assign SC_STATEMACHINEWINDOW_LOADERR = load_err_q;

`ifdef SC_STATEMACHINEWINDOW_COUNT_EN
    logic [7:0] done_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            done_cnt_q <= '0;
        end else if ((state_q == ST_CLOSE) && (done_cnt_q != 8'hFF)) begin
            done_cnt_q <= done_cnt_q + 8'd1;
        end
    end

    assign SC_STATEMACHINEWINDOW_COUNT = done_cnt_q;
`else
    // Without the counter option no completion history is kept.
`endif

endmodule
